// File: rtl/volume_pkg.sv
// rtl/volume_pkg.sv - shared volume types, limits and gain conversion
package volume_pkg;

  localparam int VOL_W = 4;

  typedef logic [VOL_W-1:0] vol_t;

  localparam vol_t MAX_VOL = 4'd15;
  localparam vol_t MIN_VOL = 4'd0;

  // Duplicating the nibble gives level * 17, spanning 0x00..0xFF exactly.
  function automatic logic [2*VOL_W-1:0] vol_to_gain(vol_t v);
    return {v, v};
  endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - button rise detector with optional hold auto-repeat (VOL_AUTOREPEAT_EN)
module button_edge
`ifdef VOL_AUTOREPEAT_EN
#(
  parameter int unsigned REPEAT_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic resetn,
  input  logic btn,
`ifdef VOL_AUTOREPEAT_EN
  input  logic other,
`endif
  output logic step
);

  logic btn_q;
  logic rise;

  assign rise = btn & ~btn_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

`ifdef VOL_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             held;
  logic             rpt;

  // cnt counts edges since the last step; zero means no qualifying hold is in
  // progress, so a hold that did not start with a clean rise never repeats.
  assign held = btn & ~other;
  assign rpt  = held & ~rise & (cnt == CNT_W'(REPEAT_CYCLES));

  always_ff @(posedge clk) begin
    if (!resetn || !held) begin
      cnt <= '0;
    end else if (rise || rpt) begin
      cnt <= CNT_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step = rise | rpt;
`else
  assign step = rise;
`endif

endmodule

// File: rtl/volume_register.sv
// rtl/volume_register.sv - saturating master-volume level with hex and gain outputs
// Optional hold auto-repeat is compiled in with VOL_AUTOREPEAT_EN.
module volume_register
  import volume_pkg::*;
#(
  parameter int unsigned DEFAULT_VOL   = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Vol_up,
  input  logic       Vol_down,
  output logic [7:0] Data,
  output logic [3:0] hex_vol
);

  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  vol_t level;
  logic up_step;
  logic down_step;

`ifdef VOL_AUTOREPEAT_EN
  button_edge #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
    .clk    (Clk),
    .resetn (Reset),
    .btn    (Vol_up),
    .other  (Vol_down),
    .step   (up_step)
  );

  button_edge #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_down (
    .clk    (Clk),
    .resetn (Reset),
    .btn    (Vol_down),
    .other  (Vol_up),
    .step   (down_step)
  );
`else
  button_edge u_up (
    .clk    (Clk),
    .resetn (Reset),
    .btn    (Vol_up),
    .step   (up_step)
  );

  button_edge u_down (
    .clk    (Clk),
    .resetn (Reset),
    .btn    (Vol_down),
    .step   (down_step)
  );
`endif

  // Opposing steps in the same cycle cancel; limits are checked before the
  // add/subtract so the 4-bit level never wraps.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      level <= vol_t'(DEFAULT_VOL);
    end else if (up_step && !down_step) begin
      if (level != MAX_VOL) level <= level + 1'b1;
    end else if (down_step && !up_step) begin
      if (level != MIN_VOL) level <= level - 1'b1;
    end
  end

  assign hex_vol = level;
  assign Data    = vol_to_gain(level);

endmodule

// File: tb/tb_volume_register.sv
// tb/tb_volume_register.sv - directed and randomized check of volume_register against a reference model
module tb_volume_register;

  localparam int RPT = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Vol_up;
  logic       Vol_down;
  logic [7:0] Data;
  logic [3:0] hex_vol;

  int total = 0;
  int bad   = 0;

  int m_lvl;
  bit m_pu, m_pd;
  int m_run_u, m_run_d;

  always #5 Clk = ~Clk;

  volume_register #(.DEFAULT_VOL(8), .REPEAT_CYCLES(RPT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Vol_up   (Vol_up),
    .Vol_down (Vol_down),
    .Data     (Data),
    .hex_vol  (hex_vol)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare mid-cycle.
  task automatic cycle(input bit rst_n, input bit up, input bit dn);
    bit su, sd;
    Reset = rst_n; Vol_up = up; Vol_down = dn;
    @(posedge Clk);
    if (!rst_n) begin
      m_lvl = 8; m_pu = 0; m_pd = 0; m_run_u = 0; m_run_d = 0;
    end else begin
      su = up && !m_pu;
      sd = dn && !m_pd;
`ifdef VOL_AUTOREPEAT_EN
      if (!(up && !dn)) m_run_u = 0;
      else if (su) m_run_u = 1;
      else if (m_run_u > 0) begin
        m_run_u++;
        if ((m_run_u - 1) % RPT == 0) su = 1;
      end
      if (!(dn && !up)) m_run_d = 0;
      else if (sd) m_run_d = 1;
      else if (m_run_d > 0) begin
        m_run_d++;
        if ((m_run_d - 1) % RPT == 0) sd = 1;
      end
`endif
      if (su && !sd) m_lvl = (m_lvl + 1 > 15) ? 15 : m_lvl + 1;
      if (sd && !su) m_lvl = (m_lvl - 1 < 0) ? 0 : m_lvl - 1;
      m_pu = up; m_pd = dn;
    end
    @(negedge Clk);
    chk("hex_vol", int'(hex_vol), m_lvl);
    chk("data", int'(Data), m_lvl * 17);
  endtask

  initial begin
    Reset = 1'b0; Vol_up = 1'b0; Vol_down = 1'b0;
    m_lvl = 0; m_pu = 0; m_pd = 0; m_run_u = 0; m_run_d = 0;
    @(negedge Clk);

    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("reset_hex", int'(hex_vol), 8);
    chk("reset_data", int'(Data), 8'h88);

    for (int i = 0; i < 10; i++) cycle(1, 1, 0);
`ifndef VOL_AUTOREPEAT_EN
    chk("held_up_hex", int'(hex_vol), 9);
    chk("held_up_data", int'(Data), 8'h99);
`endif
    cycle(1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0);
      cycle(1, 0, 0);
    end
    chk("sat_hi_hex", int'(hex_vol), 15);
    chk("sat_hi_data", int'(Data), 8'hFF);

    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 1);
      cycle(1, 0, 0);
    end
    chk("sat_lo_hex", int'(hex_vol), 0);
    chk("sat_lo_data", int'(Data), 8'h00);

    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0);
      cycle(1, 0, 0);
    end
    cycle(1, 1, 1);
    chk("both_hex", int'(hex_vol), 5);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0);
    chk("no_new_edge_hex", int'(hex_vol), 5);
    cycle(1, 0, 0);

    // Reset dominates a press, and a button held through reset release steps once.
    cycle(0, 1, 0);
    chk("reset_dom_hex", int'(hex_vol), 8);
    cycle(1, 1, 0);
    chk("held_thru_reset_hex", int'(hex_vol), 9);
    cycle(1, 0, 0);

`ifdef VOL_AUTOREPEAT_EN
    cycle(0, 0, 0);
    for (int i = 0; i < 13; i++) cycle(1, 1, 0);
    chk("autorepeat_hex", int'(hex_vol), 12);
    cycle(0, 1, 0);
    chk("autorepeat_reset_hex", int'(hex_vol), 8);
    cycle(1, 0, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      bit up, dn, rst_n;
      int hold;
      rst_n = ($urandom_range(0, 39) != 0);
      up    = $urandom_range(0, 1);
      dn    = ($urandom_range(0, 2) == 0);
      hold  = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) cycle(rst_n, up, dn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/volume_register.md
Name: volume_register

Overview:
- Master-volume state register for the pedal-board output stage.
- Converts Vol_up/Vol_down button levels into a saturating 4-bit volume level.
- Outputs the level for the hex display (hex_vol) and an 8-bit gain word (Data) consumed by the output scaler.
- Single clock domain; inputs are already synchronised to Clk.

Parameters:
- DEFAULT_VOL, 8, volume level loaded on reset (0..15).
- REPEAT_CYCLES, 4, auto-repeat period in Clk cycles; used only when the optional feature is compiled in (must be ≥2).

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Vol_up  in  1  volume-up button level, 1 = pressed.
- Vol_down  in  1  volume-down button level, 1 = pressed.
- Data  out  8  gain word = level × 17 (0x00..0xFF).
- hex_vol  out  4  current volume level, 0..15.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - level ← DEFAULT_VOL; up_q, down_q ← 0; repeat counter ← 0.
  - hex_vol = 8, Data = 0x88 from the following cycle.
  - Reset dominates all other inputs.
- Edge detect:
  - up_q/down_q register the previous-cycle button levels.
  - up_step = Vol_up & ~up_q; down_step = Vol_down & ~down_q.
  - Since up_q/down_q clear on reset, a button held through reset release yields exactly one step.
- Level update at each rising edge (Reset=1):
  - up_step only: level ← min(level+1, 15).
  - down_step only: level ← max(level−1, 0).
  - Both steps in the same cycle: level unchanged.
  - A held button produces no further steps (without the optional feature).
- Saturation: no wrap-around; up at 15 stays 15, down at 0 stays 0.
- Outputs:
  - hex_vol = level register.
  - Data = {level, level}, i.e. level × 17, combinational from the level register.
  - Both outputs change in the cycle after the edge that detected the step (1-cycle latency from button rise).
- Arithmetic: level is 4-bit unsigned. Saturation checks precede the add/subtract, so there is no overflow.

Optional Feature:
- Macro VOL_AUTOREPEAT_EN.
- Defined:
  - While exactly one button is held (the other low), a counter runs from the initial step.
  - Every REPEAT_CYCLES cycles of continuous hold, one further step in that direction is generated.
  - Saturation still applies.
  - Counter clears on release, when both buttons are pressed, or on reset.
- Undefined: counter logic is absent; exactly one step per rising edge.

Decomposition:
- Package volume_pkg:
  - VOL_W = 4, MAX_VOL = 15, MIN_VOL = 0.
  - typedef logic [3:0] vol_t.
  - function vol_to_gain(vol_t) returning {v, v}.
- Sub-module button_edge: per-button previous-level register plus rise pulse. It also contains the auto-repeat counter under VOL_AUTOREPEAT_EN.
- Instantiate button_edge twice (up, down).

Test Plan:
- Hold Reset=0 for 2 cycles, buttons 0 → hex_vol=8, Data=0x88.
- Release reset, Vol_up 0→1 held 10 cycles (macro off) → hex_vol=9, Data=0x99 one cycle after the rise; unchanged thereafter.
- From 9, apply 8 separate up pulses (1 cycle high, 1 low) → hex_vol=15, Data=0xFF; further pulses leave it at 15.
- From 15, apply 16 down pulses → hex_vol=0, Data=0x00 after the 15th; the 16th leaves it at 0.
- From 5, Vol_up and Vol_down rise together → hex_vol stays 5. Then drop Vol_down and keep Vol_up high → still 5 (no new up edge).
- VOL_AUTOREPEAT_EN defined, REPEAT_CYCLES=4, from 8: hold Vol_up 13 cycles → 9, then 10, 11, 12 at 4-cycle spacing. Assert Reset=0 mid-hold → 8 next cycle, counter cleared.
